exec_sequencer: RTL and testbench

Single-issue execute sequencer that drives the register array and ALU from the control side. It accepts one decoded instruction at a time over a valid/ready handshake, issues the operand reads to the register array, steers the ALU, writes the ALU result back, and latches the ALU flags. It sits between instruction fetch/decode and the `regarray`/`alu` pair inside `processor`, and owns the `en`, `we`, `sela`, `selb`, `write` and `sel` nets.

---
 rtl/exec_sequencer.sv | 126 ++++++++++++
 tb/tb_exec_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Single-issue execute sequencer: IDLE -> READ -> EXEC -> WB, steering the
// register array and ALU for one instruction at a time, freezable by halt.
module exec_sequencer #(
  parameter int              REG_AW = 6,
  parameter int              DATA_W = 8,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] CMP_OP = 4'hF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [OP_W+3*REG_AW-1:0] in_instr,
  output logic                     in_ready,
  input  logic                     halt,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [2:0]               alu_flags,
  output logic                     en,
  output logic                     we,
  output logic [REG_AW-1:0]        sela,
  output logic [REG_AW-1:0]        selb,
  output logic [DATA_W-1:0]        write,
  output logic [OP_W-1:0]          alu_sel,
  output logic [2:0]               flags_q,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            r_state;
  logic [OP_W-1:0]   r_op;
  logic [REG_AW-1:0] r_dest;
  logic [REG_AW-1:0] r_srca;
  logic [REG_AW-1:0] r_srcb;
  logic [2:0]        r_flags;
  logic              r_done;
  logic              w_cmp;

  assign w_cmp = (r_op == CMP_OP);

  // Every transition is gated by !halt so a freeze never skips or repeats a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_dest  <= '0;
      r_srca  <= '0;
      r_srcb  <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!halt) begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_op    <= in_instr[OP_W+3*REG_AW-1 -: OP_W];
              r_dest  <= in_instr[3*REG_AW-1 -: REG_AW];
              r_srca  <= in_instr[2*REG_AW-1 -: REG_AW];
              r_srcb  <= in_instr[REG_AW-1:0];
              r_state <= S_READ;
            end
          end
          S_READ: r_state <= S_EXEC;
          S_EXEC: r_state <= S_WB;
          S_WB: begin
            r_flags <= alu_flags;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath steering decoded from the registered state; halt only masks the strobes.
  always_comb begin
    en      = 1'b0;
    we      = 1'b0;
    sela    = '0;
    selb    = '0;
    write   = '0;
    alu_sel = '0;
    case (r_state)
      S_READ: begin
        en   = 1'b1;
        sela = r_srca;
        selb = r_srcb;
      end
      S_EXEC: begin
        en      = 1'b1;
        sela    = r_srca;
        selb    = r_srcb;
        alu_sel = r_op;
      end
      S_WB: begin
        en   = 1'b1;
        selb = r_srcb;
        if (w_cmp) begin
          sela = r_srca;
        end else begin
          we    = 1'b1;
          sela  = r_dest;
          write = alu_out;
        end
      end
      default: ;
    endcase
    if (halt) begin
      en = 1'b0;
      we = 1'b0;
    end
  end

  assign in_ready = (r_state == S_IDLE) && !halt;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign flags_q  = r_flags;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a register-array/ALU environment, an
// instruction-level model of the sequencer, and directed scenarios.
module tb_exec_sequencer;

  localparam logic [3:0] CMP = 4'hF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [21:0] in_instr;
  logic        in_ready;
  logic        halt;
  logic [7:0]  alu_out;
  logic [2:0]  alu_flags;
  logic        en, we, busy, done;
  logic [5:0]  sela, selb;
  logic [7:0]  write;
  logic [3:0]  alu_sel;
  logic [2:0]  flags_q;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;
  bit started = 0;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .halt(halt), .alu_out(alu_out), .alu_flags(alu_flags),
    .en(en), .we(we), .sela(sela), .selb(selb), .write(write),
    .alu_sel(alu_sel), .flags_q(flags_q), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU behaviour: result[7:0] with flags {zero, carry/borrow, negative} in [10:8]
  function automatic logic [10:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    case (op)
      4'h0:       t = {1'b0, a} + {1'b0, b};
      4'h1, CMP:  t = {1'b0, a} - {1'b0, b};
      4'h2:       t = {1'b0, a & b};
      default:    t = {1'b0, a ^ b};
    endcase
    return {(t[7:0] == 8'h00), t[8], t[7], t[7:0]};
  endfunction

  // Environment: register array and two-stage ALU driven by the DUT strobes
  logic [7:0]  rf [64];
  logic [7:0]  opa, opb;
  logic [10:0] alu_r;
  initial begin opa = 0; opb = 0; alu_r = 0; end
  always @(posedge clk) begin
    if (en) begin
      opa   <= rf[sela];
      opb   <= rf[selb];
      alu_r <= alu_f(alu_sel, opa, opb);
      if (we) rf[sela] <= write;
    end
  end
  assign alu_out   = alu_r[7:0];
  assign alu_flags = alu_r[10:8];

  // Instruction-level model: in-flight flag, unhalted cycles since accept, architectural state
  logic [7:0]  m_rf [64];
  bit          m_busy;
  int          m_age;
  logic [21:0] m_instr;
  logic [2:0]  m_flags;
  bit          m_done;
  logic [10:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 0;
      m_age   <= 0;
      m_instr <= '0;
      m_flags <= '0;
      m_done  <= 0;
    end else begin
      m_done <= 0;
      if (!halt) begin
        if (!m_busy) begin
          if (in_valid) begin
            m_instr <= in_instr;
            m_busy  <= 1;
            m_age   <= 1;
          end
        end else if (m_age == 3) begin
          m_res = alu_f(m_instr[21:18], m_rf[m_instr[11:6]], m_rf[m_instr[5:0]]);
          if (m_instr[21:18] != CMP) m_rf[m_instr[17:12]] <= m_res[7:0];
          m_flags <= m_res[10:8];
          m_busy  <= 0;
          m_age   <= 0;
          m_done  <= 1;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [3:0]  e_op;
  logic [5:0]  e_sela;
  logic [10:0] e_res;
  bit          e_wb_wr;
  always @(negedge clk) begin
    if (started && rst_n) begin
      e_op    = m_instr[21:18];
      e_wb_wr = m_busy && (m_age == 3) && (e_op != CMP);
      e_sela  = !m_busy ? 6'd0 : (e_wb_wr ? m_instr[17:12] : m_instr[11:6]);
      chk("in_ready", in_ready, !m_busy && !halt);
      chk("busy",     busy,     m_busy);
      chk("en",       en,       m_busy && !halt);
      chk("we",       we,       e_wb_wr && !halt);
      chk("sela",     sela,     e_sela);
      chk("selb",     selb,     m_busy ? m_instr[5:0] : 6'd0);
      chk("done",     done,     m_done);
      chk("flags_q",  flags_q,  m_flags);
      if (!m_busy) begin
        chk("alu_sel_idle", alu_sel, 0);
        chk("write_idle",   write,   0);
      end
      if (m_busy && m_age == 2) chk("alu_sel_exec", alu_sel, e_op);
      if (e_wb_wr) begin
        e_res = alu_f(e_op, m_rf[m_instr[11:6]], m_rf[m_instr[5:0]]);
        chk("write_wb", write, e_res[7:0]);
      end
    end
  end

  // Caller sits just after a falling edge; leaves in_valid high once the offer is taken
  task automatic offer(input logic [3:0] op, input logic [5:0] d, input logic [5:0] a, input logic [5:0] b);
    bit taken = 0;
    in_valid = 1'b1;
    in_instr = {op, d, a, b};
    for (int i = 0; i < 40 && !taken; i++) begin
      if (in_ready) begin
        acc = cyc + 1;
        taken = 1;
      end
      @(negedge clk); #1;
    end
    if (!taken) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int lat);
    bit seen = 0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - acc + 1;
        seen = 1;
      end
    end
    #1;
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  int lat;
  int acc1;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; halt = 1'b0;
    for (int i = 0; i < 64; i++) rf[i] = 8'(i * 5);
    rf[0] = 8'h10; rf[1] = 8'h03; rf[2] = 8'h04; rf[63] = 8'hF5;
    for (int i = 0; i < 64; i++) m_rf[i] = rf[i];
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_we", we, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_sela", sela, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1; started = 1;

    // Halt in IDLE blocks the handshake
    halt = 1'b1; in_valid = 1'b1; in_instr = {4'h0, 6'd5, 6'd1, 6'd2};
    #1 chk("halt_idle_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    #1 chk("halt_idle_busy", busy, 0);
    halt = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;

    // ADD r5 = r1 + r2
    offer(4'h0, 6'd5, 6'd1, 6'd2);
    in_valid = 1'b0;
    chk("add_read_sela", sela, 1);
    chk("add_read_selb", selb, 2);
    @(negedge clk); @(negedge clk); #1;
    chk("add_wb_we", we, 1);
    chk("add_wb_sela", sela, 5);
    chk("add_wb_write", write, 8'h07);
    wait_done(lat);
    chk("add_latency", lat, 4);
    chk("add_flags", flags_q, 3'b000);
    chk("add_rf5", rf[5], 8'h07);
    chk("add_model_rf5", m_rf[5], 8'h07);

    // CMP r3, r3: flags only
    offer(CMP, 6'd9, 6'd3, 6'd3);
    in_valid = 1'b0;
    wait_done(lat);
    chk("cmp_latency", lat, 4);
    chk("cmp_flags", flags_q, 3'b100);
    chk("cmp_rf9", rf[9], 8'h2D);

    // Back-to-back with dependency: r10 = r1 + r2; r11 = r10 + r1
    offer(4'h0, 6'd10, 6'd1, 6'd2);
    acc1 = acc;
    offer(4'h0, 6'd11, 6'd10, 6'd1);
    in_valid = 1'b0;
    chk("b2b_spacing", acc - acc1, 4);
    wait_done(lat);
    chk("b2b_rf10", rf[10], 8'h07);
    chk("b2b_rf11", rf[11], 8'h0A);

    // SUB r6 = r2 - r1 with 3-cycle halt in EXEC
    offer(4'h1, 6'd6, 6'd2, 6'd1);
    in_valid = 1'b0;
    @(negedge clk); #1;
    halt = 1'b1;
    #1 chk("halt_en", en, 0);
    chk("halt_we", we, 0);
    repeat (3) @(negedge clk);
    #1 halt = 1'b0;
    wait_done(lat);
    chk("halt_latency", lat, 7);
    chk("halt_rf6", rf[6], 8'h01);

    // Address extremes: r63 = r0 + r63
    offer(4'h0, 6'd63, 6'd0, 6'd63);
    in_valid = 1'b0;
    chk("ext_sela", sela, 0);
    chk("ext_selb", selb, 63);
    wait_done(lat);
    chk("ext_rf63", rf[63], 8'h05);
    chk("ext_flags", flags_q, 3'b010);

    // Reset pulse during WB aborts the write
    offer(4'h0, 6'd20, 6'd1, 6'd2);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rp_wb_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("rp_we_async", we, 0);
    chk("rp_en", en, 0);
    chk("rp_busy", busy, 0);
    chk("rp_sela", sela, 0);
    chk("rp_write", write, 0);
    chk("rp_flags", flags_q, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rp_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rp_no_done", done, 0);
    chk("rp_rf20", rf[20], 8'h64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
